// File: rtl/gcd_req_arbiter_pkg.sv
// Shared definitions for the GCD request arbiter: FSM state encoding,
// default datapath width and a small modulo helper for the rr pointer.
package gcd_req_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_t;

  // Increment with wrap back to zero at the modulus (modulus need not be a power of two).
  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/gcd_req_arbiter_rr_pick.sv
// Round-robin picker: grants the first requesting bit at or after ptr,
// wrapping around. Purely combinational so any shared-resource arbiter can reuse it.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  // Bits at or above the pointer get first priority; the rest are the wrap-around.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (IW'(gi) >= ptr);
    end
  endgenerate

  assign masked = req & upper_mask;
  assign pick   = (|masked) ? masked : req;
  assign grant  = pick & (~pick + N'(1));
  assign any    = |req;

  // Encode the one-hot grant into an index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/gcd_req_arbiter.sv
// Shares one GCD datapath between NUM_REQ requesters: round-robin grant,
// operand launch, done capture with stale-done drain, zero-operand shortcut,
// watchdog abort and a valid/ready response channel tagged with requester id.
module gcd_req_arbiter
  import gcd_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_err,
  output logic [WIDTH-1:0]         gcd_x,
  output logic [WIDTH-1:0]         gcd_y,
  output logic                     gcd_go,
  input  logic                     gcd_done,
  input  logic [WIDTH-1:0]         gcd_out,
  output logic                     busy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t          state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [WD_W-1:0]     wdog_reg, wdog_next;
  logic [WIDTH-1:0]    gcd_x_reg, gcd_x_next;
  logic [WIDTH-1:0]    gcd_y_reg, gcd_y_next;
  logic                gcd_go_reg, gcd_go_next;
  logic [NUM_REQ-1:0]  req_ready_reg, req_ready_next;
  logic [ID_W-1:0]     resp_id_reg, resp_id_next;
  logic [WIDTH-1:0]    resp_data_reg, resp_data_next;
  logic                resp_err_reg, resp_err_next;

  logic [NUM_REQ-1:0]  grant_onehot;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic [WIDTH-1:0]    masked_x [NUM_REQ];
  logic [WIDTH-1:0]    masked_y [NUM_REQ];
  logic [WIDTH-1:0]    sel_x, sel_y;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (grant_onehot),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Per-requester operand slices, zeroed unless that requester wins the grant.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign masked_x[gi] = grant_onehot[gi] ? req_x[gi*WIDTH +: WIDTH] : '0;
      assign masked_y[gi] = grant_onehot[gi] ? req_y[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  // OR-reduce the masked slices into the granted requester's operands.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_x = sel_x | masked_x[i];
      sel_y = sel_y | masked_y[i];
    end
  end

  // Next-state and registered-output logic for the single in-flight job.
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    wdog_next      = wdog_reg;
    gcd_x_next     = gcd_x_reg;
    gcd_y_next     = gcd_y_reg;
    gcd_go_next    = gcd_go_reg;
    req_ready_next = '0;
    resp_id_next   = resp_id_reg;
    resp_data_next = resp_data_reg;
    resp_err_next  = resp_err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready_next = grant_onehot;
          gcd_x_next     = sel_x;
          gcd_y_next     = sel_y;
          resp_id_next   = grant_idx;
          resp_err_next  = 1'b0;
          rr_ptr_next    = ID_W'(wrap_inc(int'(grant_idx), NUM_REQ));
          // A zero operand makes the result trivial; the datapath is never started.
          if (sel_x == '0) begin
            resp_data_next = sel_y;
            state_next     = ST_RESP;
          end else if (sel_y == '0) begin
            resp_data_next = sel_x;
            state_next     = ST_RESP;
          end else begin
            gcd_go_next = 1'b1;
            wdog_next   = '0;
            state_next  = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        wdog_next  = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // Done takes priority over a watchdog expiring in the same cycle.
        if (gcd_done) begin
          resp_data_next = gcd_out;
          gcd_go_next    = 1'b0;
          state_next     = ST_DRAIN;
        end else if (wdog_reg == WD_LAST) begin
          resp_data_next = '0;
          resp_err_next  = 1'b1;
          gcd_go_next    = 1'b0;
          state_next     = ST_DRAIN;
        end else begin
          wdog_next = wdog_reg + WD_W'(1);
        end
      end
      ST_DRAIN: begin
        // Let a lingering done fall before the next job can see it.
        if (!gcd_done) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_err_next = 1'b0;
          state_next    = ST_IDLE;
        end
      end
      default: begin
        gcd_go_next = 1'b0;
        state_next  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      wdog_reg      <= '0;
      gcd_x_reg     <= '0;
      gcd_y_reg     <= '0;
      gcd_go_reg    <= 1'b0;
      req_ready_reg <= '0;
      resp_id_reg   <= '0;
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      wdog_reg      <= wdog_next;
      gcd_x_reg     <= gcd_x_next;
      gcd_y_reg     <= gcd_y_next;
      gcd_go_reg    <= gcd_go_next;
      req_ready_reg <= req_ready_next;
      resp_id_reg   <= resp_id_next;
      resp_data_reg <= resp_data_next;
      resp_err_reg  <= resp_err_next;
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_id    = resp_id_reg;
  assign resp_data  = resp_data_reg;
  assign resp_err   = resp_err_reg;
  assign gcd_x      = gcd_x_reg;
  assign gcd_y      = gcd_y_reg;
  assign gcd_go     = gcd_go_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Bench for gcd_req_arbiter: emulated GCD datapath, auto-dropping requesters,
// a transaction-level model checked every cycle, and directed scenarios.
module tb_gcd_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 16;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_x, req_y;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid, resp_ready, resp_err;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_data, gcd_x, gcd_y, gcd_out;
  logic                     gcd_go, gcd_done, busy;

  int checks = 0;
  int failures = 0;
  bit tie_low = 1'b0;
  int dp_dly = 2;
  logic [NUM_REQ-1:0] sticky = '0;
  int pulse_cnt [NUM_REQ];
  int log_n = 0;
  int log_id [32];
  logic [WIDTH-1:0] log_data [32];
  logic log_err [32];

  gcd_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .gcd_x      (gcd_x),
    .gcd_y      (gcd_y),
    .gcd_go     (gcd_go),
    .gcd_done   (gcd_done),
    .gcd_out    (gcd_out),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in);
    logic [WIDTH-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [NUM_REQ*WIDTH-1:0] m, vx, vy;
    m = '0;
    m[WIDTH-1:0] = '1;
    m = m << (i * WIDTH);
    vx = '0;
    vx[WIDTH-1:0] = x;
    vx = vx << (i * WIDTH);
    vy = '0;
    vy[WIDTH-1:0] = y;
    vy = vy << (i * WIDTH);
    req_x = (req_x & ~m) | vx;
    req_y = (req_y & ~m) | vy;
    req_valid = req_valid | (NUM_REQ'(1) << i);
  endtask

  task automatic wait_log(input int n, input int budget);
    int c;
    c = 0;
    while (log_n < n && c < budget) begin
      @(negedge clock);
      c++;
    end
    chk("log_count_reached", log_n, n);
  endtask

  // Emulated GCD datapath: done rises a few cycles after go and falls once go drops.
  initial begin : datapath
    int cnt;
    cnt = 0;
    gcd_done = 1'b0;
    gcd_out = '0;
    forever begin
      @(negedge clock);
      if (reset || !gcd_go) begin
        gcd_done = 1'b0;
        cnt = 0;
      end else if (tie_low) begin
        gcd_done = 1'b0;
      end else if (cnt >= dp_dly) begin
        gcd_done = 1'b1;
        gcd_out = gcd_ref(gcd_x, gcd_y);
      end else begin
        cnt++;
      end
    end
  end

  // Requesters withdraw their strobe after their accept pulse unless held sticky.
  initial begin : requesters
    forever begin
      @(negedge clock);
      req_valid = req_valid & ~(req_ready & ~sticky);
    end
  end

  // Transaction-level model: one job at a time, round-robin choice, expected result per job.
  initial begin : compare
    bit m_idle, job_active, job_zero, job_exp_err, prev_rv, prev_err;
    int m_ptr, g, c, go_cnt, job_id, prev_id;
    logic [WIDTH-1:0] job_x, job_y, job_exp, prev_data;
    logic [NUM_REQ-1:0] tv;
    logic [NUM_REQ*WIDTH-1:0] tw;
    m_idle = 1; job_active = 0; job_zero = 0; job_exp_err = 0; prev_rv = 0; prev_err = 0;
    m_ptr = 0; go_cnt = 0; job_id = 0; prev_id = 0;
    job_x = '0; job_y = '0; job_exp = '0; prev_data = '0;
    for (int i = 0; i < NUM_REQ; i++) pulse_cnt[i] = 0;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        tv = req_ready >> i;
        if (tv[0] === 1'b1) pulse_cnt[i]++;
      end
      if (reset) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_gcd_go", gcd_go, 0);
        chk("rst_gcd_x", gcd_x, 0);
        chk("rst_gcd_y", gcd_y, 0);
        chk("rst_busy", busy, 0);
        m_idle = 1; m_ptr = 0; job_active = 0; prev_rv = 0;
      end else begin
        if (m_idle && req_valid != '0) begin
          g = -1;
          for (int k = 0; k < NUM_REQ; k++) begin
            c = (m_ptr + k) % NUM_REQ;
            tv = req_valid >> c;
            if (g < 0 && tv[0]) g = c;
          end
          chk("grant_onehot", req_ready, NUM_REQ'(1) << g);
          tw = req_x >> (g * WIDTH);
          job_x = tw[WIDTH-1:0];
          tw = req_y >> (g * WIDTH);
          job_y = tw[WIDTH-1:0];
          job_id = g;
          job_zero = (job_x == 0) || (job_y == 0);
          if (job_x == 0) job_exp = job_y;
          else if (job_y == 0) job_exp = job_x;
          else if (tie_low) job_exp = '0;
          else job_exp = gcd_ref(job_x, job_y);
          job_exp_err = !job_zero && tie_low;
          go_cnt = 0;
          m_ptr = (g + 1) % NUM_REQ;
          m_idle = 0;
          job_active = 1;
          chk("zero_op_latency", resp_valid, job_zero);
        end else begin
          chk("no_grant", req_ready, 0);
        end
        if (prev_rv && resp_ready) begin
          if (log_n < 32) begin
            log_id[log_n] = prev_id;
            log_data[log_n] = prev_data;
            log_err[log_n] = prev_err;
            log_n++;
          end
          $display("resp id=%0d data=%0d err=%0d", prev_id, prev_data, prev_err);
          m_idle = 1;
          job_active = 0;
        end
        if (job_active) begin
          if (gcd_go) begin
            go_cnt++;
            chk("go_operand_x", gcd_x, job_x);
            chk("go_operand_y", gcd_y, job_y);
          end
          if (job_zero) chk("zero_op_no_go", gcd_go, 0);
          if (resp_valid) begin
            chk("resp_id", resp_id, job_id);
            chk("resp_data", resp_data, job_exp);
            chk("resp_err", resp_err, job_exp_err);
            if (job_exp_err) chk("watchdog_go_cycles", go_cnt, TIMEOUT + 1);
          end
        end else begin
          chk("idle_resp_valid", resp_valid, 0);
          chk("idle_gcd_go", gcd_go, 0);
        end
        chk("busy", busy, !m_idle);
        prev_rv = resp_valid;
        prev_id = int'(resp_id);
        prev_data = resp_data;
        prev_err = resp_err;
      end
    end
  end

  // Directed scenarios.
  initial begin : main
    int base1, base3, c;
    int exp_id [4];
    int exp_dat [4];
    reset = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    resp_ready = 1'b1;
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_gcd_go", gcd_go, 0);
    tick(3);
    reset = 1'b0;
    tick(2);

    // Single request.
    set_req(0, 624129, 2061517);
    wait_log(1, 200);
    chk("single_id", log_id[0], 0);
    chk("single_data", log_data[0], 18913);
    chk("single_err", log_err[0], 0);
    chk("single_one_pulse", pulse_cnt[0], 1);

    // Zero operand from requester 3 (also wraps the pointer back to 0).
    set_req(3, 0, 35);
    wait_log(2, 200);
    chk("zero_id", log_id[1], 3);
    chk("zero_data", log_data[1], 35);
    chk("zero_err", log_err[1], 0);

    // Contention: all four at once.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(22 * (i + 1)), 44);
    wait_log(6, 400);
    exp_id = '{0, 1, 2, 3};
    exp_dat = '{22, 44, 22, 44};
    for (int i = 0; i < 4; i++) begin
      chk("contention_id", log_id[2 + i], exp_id[i]);
      chk("contention_data", log_data[2 + i], exp_dat[i]);
    end

    // Fairness: requester 1 held, requester 2 joins while 1 is served.
    base1 = pulse_cnt[1];
    sticky[1] = 1'b1;
    set_req(1, 12, 18);
    c = 0;
    while (pulse_cnt[1] < base1 + 1 && c < 200) begin @(negedge clock); c++; end
    chk("fair_first_grant", pulse_cnt[1], base1 + 1);
    set_req(2, 35, 21);
    c = 0;
    while (pulse_cnt[1] < base1 + 2 && c < 200) begin @(negedge clock); c++; end
    chk("fair_second_grant", pulse_cnt[1], base1 + 2);
    sticky[1] = 1'b0;
    req_valid[1] = 1'b0;
    wait_log(9, 200);
    chk("fair_id0", log_id[6], 1);
    chk("fair_id1", log_id[7], 2);
    chk("fair_id2", log_id[8], 1);
    chk("fair_data0", log_data[6], 6);
    chk("fair_data1", log_data[7], 7);

    // Backpressure: response held 20 cycles, queued requester must wait.
    resp_ready = 1'b0;
    set_req(0, 9, 6);
    c = 0;
    while (!resp_valid && c < 100) begin @(negedge clock); c++; end
    chk("bp_resp_seen", resp_valid, 1);
    base3 = pulse_cnt[3];
    set_req(3, 0, 5);
    tick(20);
    chk("bp_valid_held", resp_valid, 1);
    chk("bp_id_held", resp_id, 0);
    chk("bp_data_held", resp_data, 3);
    chk("bp_err_held", resp_err, 0);
    chk("bp_no_new_grant", pulse_cnt[3], base3);
    resp_ready = 1'b1;
    wait_log(11, 200);
    chk("bp_log_id", log_id[9], 0);
    chk("bp_log_data", log_data[9], 3);
    chk("bp_next_id", log_id[10], 3);
    chk("bp_next_data", log_data[10], 5);

    // Watchdog: datapath never finishes.
    tie_low = 1'b1;
    set_req(2, 10, 4);
    wait_log(12, 200);
    tie_low = 1'b0;
    chk("wd_id", log_id[11], 2);
    chk("wd_data", log_data[11], 0);
    chk("wd_err", log_err[11], 1);

    // Asynchronous reset while waiting on the datapath.
    tie_low = 1'b1;
    set_req(1, 100, 75);
    c = 0;
    while (!gcd_go && c < 100) begin @(negedge clock); c++; end
    chk("rstw_go_seen", gcd_go, 1);
    tick(4);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("rstw_go_dropped", gcd_go, 0);
    chk("rstw_busy_dropped", busy, 0);
    chk("rstw_resp_valid", resp_valid, 0);
    tick(2);
    reset = 1'b0;
    tie_low = 1'b0;
    tick(10);
    chk("rstw_no_response", log_n, 12);

    // Pointer restarts at 0 after reset: requester 1 before 3.
    set_req(1, 100, 75);
    set_req(3, 0, 0);
    wait_log(14, 300);
    chk("post_rst_id0", log_id[12], 1);
    chk("post_rst_data0", log_data[12], 25);
    chk("post_rst_id1", log_id[13], 3);
    chk("post_rst_data1", log_data[13], 0);
    chk("post_rst_err1", log_err[13], 0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
